uart_spi_bridge: RTL and testbench



---
 rtl/uart_spi_bridge.sv | 261 ++++++++++++++++++++++++++
 tb/tb_uart_spi_bridge.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_spi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : uart_spi_bridge
// Purpose  : Parses framed UART commands (write / read / ping), runs one
//            CS-framed SPI transaction per write or read and returns a UART
//            response. Tracks inter-byte timeouts and dropped bytes/frames.
// Ports    : clk40M, nRst          - clock, async active-low reset
//            rx_valid, rx_byte     - bytes from the UART receiver
//            tx_valid, tx_byte,
//            tx_ready              - response bytes to the UART transmitter
//            spi_tx_count          - bytes per CS (ADDR_BYTES+DATA_BYTES)
//            spi_tx_byte, spi_tx_dv,
//            spi_tx_ready          - MOSI byte interface to the SPI master
//            spi_rx_dv, spi_rx_byte- MISO byte interface from the SPI master
//            busy                  - high while sending SPI or responding
//            err_count             - saturating error counter
// Revision : 1.0 - initial release
// ============================================================================
module uart_spi_bridge #(
  parameter int         ADDR_BYTES   = 2,
  parameter int         DATA_BYTES   = 2,
  parameter int         TIMEOUT_CLKS = 40000,
  parameter logic [7:0] CMD_WR       = 8'hA0,
  parameter logic [7:0] CMD_RD       = 8'hA1,
  parameter logic [7:0] CMD_PING     = 8'hA2,
  parameter logic [7:0] READ_FLAG    = 8'h80,
  parameter int         CNT_W        = $clog2(ADDR_BYTES + DATA_BYTES + 1)
) (
  input  logic             clk40M,
  input  logic             nRst,
  input  logic             rx_valid,
  input  logic [7:0]       rx_byte,
  output logic             tx_valid,
  output logic [7:0]       tx_byte,
  input  logic             tx_ready,
  output logic [CNT_W-1:0] spi_tx_count,
  output logic [7:0]       spi_tx_byte,
  output logic             spi_tx_dv,
  input  logic             spi_tx_ready,
  input  logic             spi_rx_dv,
  input  logic [7:0]       spi_rx_byte,
  output logic             busy,
  output logic [7:0]       err_count
);

  localparam int TOTAL  = ADDR_BYTES + DATA_BYTES;
  localparam int TO_W   = $clog2(TIMEOUT_CLKS + 1);
  // Response index runs 0 (cmd echo) .. DATA_BYTES (last read byte).
  localparam int RESP_W = $clog2(DATA_BYTES + 2);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RX_ADDR  = 3'd1,
    RX_DATA  = 3'd2,
    SPI_SEND = 3'd3,
    SPI_WAIT = 3'd4,
    RESP     = 3'd5
  } state_t;

  state_t             state;
  logic [7:0]         cmd;
  logic [7:0]         addr_buf [ADDR_BYTES];
  logic [7:0]         data_buf [DATA_BYTES];
  logic [7:0]         rdata    [DATA_BYTES];
  logic [CNT_W-1:0]   rx_idx;
  logic [CNT_W-1:0]   send_idx;
  logic [CNT_W-1:0]   rx_cnt;
  logic [TO_W-1:0]    to_cnt;
  logic [RESP_W-1:0]  resp_idx;

  logic               is_rd;
  logic               in_rx;
  logic               timeout_hit;
  logic               err_evt;
  logic               resp_last;
  logic [7:0]         send_byte;

  assign spi_tx_count = CNT_W'(TOTAL);

  assign is_rd       = (cmd == CMD_RD);
  assign in_rx       = (state == RX_ADDR) || (state == RX_DATA);
  assign timeout_hit = in_rx && !rx_valid && (to_cnt == TO_W'(TIMEOUT_CLKS - 1));
  assign resp_last   = (resp_idx == (is_rd ? RESP_W'(DATA_BYTES) : '0));

  // Simultaneous error sources collapse into a single increment.
  assign err_evt = (rx_valid && busy) ||
                   ((state == IDLE) && rx_valid &&
                    (rx_byte != CMD_WR) && (rx_byte != CMD_RD) && (rx_byte != CMD_PING)) ||
                   timeout_hit;

  // MOSI byte for the current send index: address first, then data or
  // zero fillers on reads.
  always_comb begin
    send_byte = 8'h00;
    for (int k = 0; k < ADDR_BYTES; k++) begin
      if (send_idx == CNT_W'(k)) begin
        send_byte = ((k == 0) && is_rd) ? (addr_buf[k] | READ_FLAG) : addr_buf[k];
      end
    end
    if (!is_rd) begin
      for (int k = 0; k < DATA_BYTES; k++) begin
        if (send_idx == CNT_W'(ADDR_BYTES + k)) begin
          send_byte = data_buf[k];
        end
      end
    end
  end

  // Response byte i: 0 is the command echo, 1.. are the read-back bytes.
  function automatic logic [7:0] resp_at(input logic [RESP_W-1:0] i);
    logic [7:0] r;
    r = cmd;
    for (int k = 0; k < DATA_BYTES; k++) begin
      if (i == RESP_W'(k + 1)) r = rdata[k];
    end
    return r;
  endfunction

  always_ff @(posedge clk40M or negedge nRst) begin
    if (!nRst) begin
      state       <= IDLE;
      cmd         <= 8'h00;
      tx_valid    <= 1'b0;
      tx_byte     <= 8'h00;
      spi_tx_dv   <= 1'b0;
      spi_tx_byte <= 8'h00;
      busy        <= 1'b0;
      err_count   <= 8'h00;
      rx_idx      <= '0;
      send_idx    <= '0;
      rx_cnt      <= '0;
      to_cnt      <= '0;
      resp_idx    <= '0;
      for (int k = 0; k < ADDR_BYTES; k++) addr_buf[k] <= 8'h00;
      for (int k = 0; k < DATA_BYTES; k++) begin
        data_buf[k] <= 8'h00;
        rdata[k]    <= 8'h00;
      end
    end else begin
      spi_tx_dv <= 1'b0;

      if (err_evt && (err_count != 8'hFF)) err_count <= err_count + 8'd1;

      // MISO bytes may start arriving while later MOSI bytes are still queued.
      if (((state == SPI_SEND) || (state == SPI_WAIT)) && spi_rx_dv &&
          (rx_cnt != CNT_W'(TOTAL))) begin
        rx_cnt <= rx_cnt + 1'b1;
        if (is_rd) begin
          for (int k = 0; k < DATA_BYTES; k++) begin
            if (rx_cnt == CNT_W'(ADDR_BYTES + k)) rdata[k] <= spi_rx_byte;
          end
        end
      end

      case (state)
        IDLE: begin
          if (rx_valid) begin
            cmd <= rx_byte;
            if ((rx_byte == CMD_WR) || (rx_byte == CMD_RD)) begin
              state  <= RX_ADDR;
              rx_idx <= '0;
              to_cnt <= '0;
            end else if (rx_byte == CMD_PING) begin
              state    <= RESP;
              busy     <= 1'b1;
              resp_idx <= '0;
            end
          end
        end

        RX_ADDR: begin
          if (rx_valid) begin
            to_cnt <= '0;
            for (int k = 0; k < ADDR_BYTES; k++) begin
              if (rx_idx == CNT_W'(k)) addr_buf[k] <= rx_byte;
            end
            if (rx_idx == CNT_W'(ADDR_BYTES - 1)) begin
              rx_idx <= '0;
              if (is_rd) begin
                state    <= SPI_SEND;
                busy     <= 1'b1;
                send_idx <= '0;
                rx_cnt   <= '0;
              end else begin
                state <= RX_DATA;
              end
            end else begin
              rx_idx <= rx_idx + 1'b1;
            end
          end else if (timeout_hit) begin
            state <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        RX_DATA: begin
          if (rx_valid) begin
            to_cnt <= '0;
            for (int k = 0; k < DATA_BYTES; k++) begin
              if (rx_idx == CNT_W'(k)) data_buf[k] <= rx_byte;
            end
            if (rx_idx == CNT_W'(DATA_BYTES - 1)) begin
              rx_idx   <= '0;
              state    <= SPI_SEND;
              busy     <= 1'b1;
              send_idx <= '0;
              rx_cnt   <= '0;
            end else begin
              rx_idx <= rx_idx + 1'b1;
            end
          end else if (timeout_hit) begin
            state <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        SPI_SEND: begin
          // Skip a cycle after every pulse so the strobe is never back-to-back.
          if (spi_tx_ready && !spi_tx_dv) begin
            spi_tx_dv   <= 1'b1;
            spi_tx_byte <= send_byte;
            send_idx    <= send_idx + 1'b1;
            if (send_idx == CNT_W'(TOTAL - 1)) state <= SPI_WAIT;
          end
        end

        SPI_WAIT: begin
          if (rx_cnt == CNT_W'(TOTAL)) begin
            state    <= RESP;
            resp_idx <= '0;
          end
        end

        RESP: begin
          if (!tx_valid) begin
            tx_valid <= 1'b1;
            tx_byte  <= resp_at(resp_idx);
          end else if (tx_ready) begin
            if (resp_last) begin
              tx_valid <= 1'b0;
              state    <= IDLE;
              busy     <= 1'b0;
            end else begin
              resp_idx <= resp_idx + 1'b1;
              tx_byte  <= resp_at(resp_idx + 1'b1);
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_spi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_spi_bridge
// Purpose  : Self-checking bench for uart_spi_bridge. A frame-level model
//            builds the expected MOSI stream, UART response and error count
//            from each command; SPI slave and UART sink are behavioural.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_spi_bridge;

  localparam int AB = 2;
  localparam int DB = 2;
  localparam int TO = 200;

  logic       clk40M = 1'b0;
  logic       nRst = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       tx_valid;
  logic [7:0] tx_byte;
  logic       tx_ready = 1'b1;
  logic [2:0] spi_tx_count;
  logic [7:0] spi_tx_byte;
  logic       spi_tx_dv;
  logic       spi_tx_ready = 1'b1;
  logic       spi_rx_dv = 1'b0;
  logic [7:0] spi_rx_byte = 8'h00;
  logic       busy;
  logic [7:0] err_count;

  uart_spi_bridge #(
    .ADDR_BYTES  (AB),
    .DATA_BYTES  (DB),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .clk40M      (clk40M),
    .nRst        (nRst),
    .rx_valid    (rx_valid),
    .rx_byte     (rx_byte),
    .tx_valid    (tx_valid),
    .tx_byte     (tx_byte),
    .tx_ready    (tx_ready),
    .spi_tx_count(spi_tx_count),
    .spi_tx_byte (spi_tx_byte),
    .spi_tx_dv   (spi_tx_dv),
    .spi_tx_ready(spi_tx_ready),
    .spi_rx_dv   (spi_rx_dv),
    .spi_rx_byte (spi_rx_byte),
    .busy        (busy),
    .err_count   (err_count)
  );

  always #5 clk40M = ~clk40M;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         exp_err = 0;
  int         cyc = 0;
  int         spi_lat = 2;
  int         consec_viol = 0;
  bit         rand_tx = 1'b0;
  bit         rand_spi = 1'b0;
  logic       tx_force = 1'b1;
  logic       spi_force = 1'b1;
  logic       prev_dv = 1'b0;
  logic [7:0] mosi_q[$];
  logic [7:0] resp_q[$];
  logic [7:0] miso_q[$];
  int         lat_q[$];

  function automatic int sat_add(input int v, input int n);
    return (v + n > 255) ? 255 : v + n;
  endfunction

  always @(posedge clk40M) cyc++;

  // Ready lines and the SPI slave's MISO strobes, driven just after the edge.
  always begin
    @(posedge clk40M);
    #1;
    tx_ready     = rand_tx  ? 1'($urandom_range(0, 1)) : tx_force;
    spi_tx_ready = rand_spi ? 1'($urandom_range(0, 1)) : spi_force;
    spi_rx_dv    = 1'b0;
    if (lat_q.size() > 0 && lat_q[0] <= cyc) begin
      void'(lat_q.pop_front());
      spi_rx_dv   = 1'b1;
      spi_rx_byte = (miso_q.size() > 0) ? miso_q.pop_front() : 8'h5A;
    end
  end

  // Capture MOSI bytes, accepted UART bytes and back-to-back strobes.
  always @(negedge clk40M) begin
    if (nRst) begin
      if (spi_tx_dv) begin
        mosi_q.push_back(spi_tx_byte);
        lat_q.push_back(cyc + spi_lat);
      end
      if (spi_tx_dv && prev_dv) consec_viol++;
      if (tx_valid && tx_ready) resp_q.push_back(tx_byte);
    end
    prev_dv = spi_tx_dv;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_b(input logic [7:0] b);
    @(posedge clk40M);
    #1;
    rx_valid = 1'b1;
    rx_byte  = b;
    @(posedge clk40M);
    #1;
    rx_valid = 1'b0;
  endtask

  // Run one frame and compare MOSI stream, UART response and err_count.
  task automatic do_frame(input string nm, input logic [7:0] cmd, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] miso_w,
                          input int gap, input int n_ovr);
    logic [7:0] em[$];
    logic [7:0] er[$];
    logic [7:0] b;
    bit         rd, wr, ok;
    int         t, bad_i;
    rd = (cmd == 8'hA1);
    wr = (cmd == 8'hA0);
    mosi_q.delete();
    resp_q.delete();
    miso_q.delete();
    if (rd || wr) begin
      for (int i = 0; i < AB + DB; i++) miso_q.push_back(miso_w[8*i +: 8]);
      for (int i = 0; i < AB; i++) begin
        b = addr[8*i +: 8];
        if (i == 0 && rd) b = b | 8'h80;
        em.push_back(b);
      end
      for (int i = 0; i < DB; i++) em.push_back(wr ? data[8*i +: 8] : 8'h00);
    end
    er.push_back(cmd);
    if (rd) for (int i = 0; i < DB; i++) er.push_back(miso_w[8*(AB+i) +: 8]);

    send_b(cmd);
    repeat (gap) @(posedge clk40M);
    if (rd || wr) begin
      for (int i = 0; i < AB; i++) send_b(addr[8*i +: 8]);
      if (wr) for (int i = 0; i < DB; i++) send_b(data[8*i +: 8]);
    end
    if (n_ovr > 0) begin
      t = 0;
      while (mosi_q.size() < AB + DB && t < 1000) begin
        @(negedge clk40M);
        t++;
      end
      for (int i = 0; i < n_ovr; i++) send_b(8'($urandom));
      exp_err = sat_add(exp_err, n_ovr);
    end

    t = 0;
    while ((resp_q.size() < er.size() || busy) && t < 3000) begin
      @(negedge clk40M);
      t++;
    end
    repeat (3) @(negedge clk40M);

    n_cmp++;
    if (t >= 3000) begin
      n_bad++;
      $display("FAIL %s_done: response not complete in time, got %0d of %0d bytes", nm, resp_q.size(), er.size());
    end

    n_cmp++;
    ok = (mosi_q.size() == em.size());
    bad_i = -1;
    for (int i = 0; i < em.size() && i < mosi_q.size(); i++)
      if (bad_i < 0 && mosi_q[i] !== em[i]) bad_i = i;
    if (!ok || bad_i >= 0) begin
      n_bad++;
      $display("FAIL %s_mosi: got %0d bytes, required %0d; first diff idx %0d got %h required %h",
               nm, mosi_q.size(), em.size(), bad_i,
               (bad_i >= 0) ? mosi_q[bad_i] : 8'h00, (bad_i >= 0) ? em[bad_i] : 8'h00);
    end

    n_cmp++;
    ok = (resp_q.size() == er.size());
    bad_i = -1;
    for (int i = 0; i < er.size() && i < resp_q.size(); i++)
      if (bad_i < 0 && resp_q[i] !== er[i]) bad_i = i;
    if (!ok || bad_i >= 0) begin
      n_bad++;
      $display("FAIL %s_resp: got %0d bytes, required %0d; first diff idx %0d got %h required %h",
               nm, resp_q.size(), er.size(), bad_i,
               (bad_i >= 0) ? resp_q[bad_i] : 8'h00, (bad_i >= 0) ? er[bad_i] : 8'h00);
    end

    n_cmp++;
    if (err_count !== 8'(exp_err)) begin
      n_bad++;
      $display("FAIL %s_err: err_count got %0d required %0d", nm, err_count, exp_err);
    end
  endtask

  task automatic test_reset();
    nRst = 1'b0;
    repeat (3) @(negedge clk40M);
    n_cmp++;
    if ({tx_valid, tx_byte, spi_tx_dv, spi_tx_byte, busy, err_count} !== 27'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: tv=%b tb=%h dv=%b sb=%h busy=%b err=%h required all 0",
               tx_valid, tx_byte, spi_tx_dv, spi_tx_byte, busy, err_count);
    end
    n_cmp++;
    if (spi_tx_count !== 3'(AB + DB)) begin
      n_bad++;
      $display("FAIL reset_count: spi_tx_count got %0d required %0d", spi_tx_count, AB + DB);
    end
    nRst = 1'b1;
    repeat (2) @(negedge clk40M);
  endtask

  task automatic test_write();
    do_frame("wr", 8'hA0, 32'h1234, 32'hABCD, 32'h0, 0, 0);
  endtask

  task automatic test_read();
    do_frame("rd", 8'hA1, 32'h0010, 32'h0, 32'hBEEF7788, 0, 0);
  endtask

  task automatic test_ping();
    bit stable;
    int t;
    resp_q.delete();
    tx_force = 1'b0;
    repeat (2) @(posedge clk40M);
    @(posedge clk40M);
    #1;
    rx_valid = 1'b1;
    rx_byte  = 8'hA2;
    @(posedge clk40M);
    #1;
    rx_valid = 1'b0;
    n_cmp++;
    if (tx_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL ping_lat1: tx_valid got %b required 0 one cycle after ping", tx_valid);
    end
    @(posedge clk40M);
    #1;
    n_cmp++;
    if (tx_valid !== 1'b1 || tx_byte !== 8'hA2) begin
      n_bad++;
      $display("FAIL ping_lat2: tx_valid/tx_byte got %b/%h required 1/a2", tx_valid, tx_byte);
    end
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk40M);
      if (tx_valid !== 1'b1 || tx_byte !== 8'hA2) stable = 1'b0;
    end
    n_cmp++;
    if (!stable) begin
      n_bad++;
      $display("FAIL ping_hold: tx_valid/tx_byte got %b/%h during stall required 1/a2", tx_valid, tx_byte);
    end
    tx_force = 1'b1;
    t = 0;
    while ((resp_q.size() < 1 || busy) && t < 50) begin
      @(negedge clk40M);
      t++;
    end
    repeat (5) @(negedge clk40M);
    n_cmp++;
    if (resp_q.size() != 1 || resp_q[0] !== 8'hA2 || tx_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL ping_resp: got %0d bytes first %h tx_valid %b required 1 byte a2 and tx_valid 0",
               resp_q.size(), (resp_q.size() > 0) ? resp_q[0] : 8'h00, tx_valid);
    end
  endtask

  task automatic test_errors();
    send_b(8'h55);
    exp_err = sat_add(exp_err, 1);
    repeat (2) @(negedge clk40M);
    n_cmp++;
    if (err_count !== 8'(exp_err)) begin
      n_bad++;
      $display("FAIL unknown_cmd: err_count got %0d required %0d", err_count, exp_err);
    end
    spi_lat = 20;
    do_frame("rd_ovr", 8'hA1, 32'h0000_4321, 32'h0, 32'hBEEF_0000 | 32'($urandom_range(0, 65535)), 0, 3);
    spi_lat = 2;
    n_cmp++;
    if (consec_viol != 0) begin
      n_bad++;
      $display("FAIL dv_spacing: back-to-back spi_tx_dv got %0d required 0", consec_viol);
    end
  endtask

  task automatic test_timeout();
    mosi_q.delete();
    send_b(8'hA0);
    send_b(8'h34);
    repeat (TO + 5) @(negedge clk40M);
    exp_err = sat_add(exp_err, 1);
    n_cmp++;
    if (err_count !== 8'(exp_err) || mosi_q.size() != 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout: err %0d mosi %0d busy %b required err %0d mosi 0 busy 0",
               err_count, mosi_q.size(), busy, exp_err);
    end
    do_frame("wr_after_to", 8'hA0, 32'h5566, 32'h7788, 32'h0, 0, 0);
    do_frame("wr_gap", 8'hA0, 32'h9ABC, 32'hDEF0, 32'h0, TO / 2, 0);
  endtask

  task automatic test_random();
    int         sel;
    logic [7:0] b;
    rand_tx  = 1'b1;
    rand_spi = 1'b1;
    for (int it = 0; it < 25; it++) begin
      spi_lat = $urandom_range(1, 6);
      sel = $urandom_range(0, 9);
      if (sel <= 3)
        do_frame("rnd_wr", 8'hA0, 32'($urandom), 32'($urandom), 32'($urandom), 0, 0);
      else if (sel <= 7)
        do_frame("rnd_rd", 8'hA1, 32'($urandom), 32'($urandom), 32'($urandom), 0, 0);
      else if (sel == 8)
        do_frame("rnd_ping", 8'hA2, 32'h0, 32'h0, 32'h0, 0, 0);
      else begin
        b = 8'($urandom_range(0, 255));
        while (b == 8'hA0 || b == 8'hA1 || b == 8'hA2) b = 8'($urandom_range(0, 255));
        send_b(b);
        exp_err = sat_add(exp_err, 1);
        repeat (2) @(negedge clk40M);
        n_cmp++;
        if (err_count !== 8'(exp_err)) begin
          n_bad++;
          $display("FAIL rnd_unknown: err_count got %0d required %0d", err_count, exp_err);
        end
      end
    end
    rand_tx  = 1'b0;
    rand_spi = 1'b0;
    spi_lat  = 2;
    repeat (3) @(negedge clk40M);
    n_cmp++;
    if (consec_viol != 0) begin
      n_bad++;
      $display("FAIL rnd_dv_spacing: back-to-back spi_tx_dv got %0d required 0", consec_viol);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 260; i++) begin
      send_b(8'h55);
      exp_err = sat_add(exp_err, 1);
    end
    repeat (2) @(negedge clk40M);
    n_cmp++;
    if (err_count !== 8'(exp_err)) begin
      n_bad++;
      $display("FAIL err_saturate: err_count got %0d required %0d", err_count, exp_err);
    end
  endtask

  task automatic test_reset_mid();
    int m, r, t;
    mosi_q.delete();
    resp_q.delete();
    send_b(8'hA0);
    send_b(8'h11);
    send_b(8'h22);
    send_b(8'h33);
    send_b(8'h44);
    t = 0;
    while (mosi_q.size() < 2 && t < 200) begin
      @(negedge clk40M);
      t++;
    end
    nRst = 1'b0;
    #1;
    n_cmp++;
    if ({tx_valid, tx_byte, spi_tx_dv, spi_tx_byte, busy, err_count} !== 27'd0 || t >= 200) begin
      n_bad++;
      $display("FAIL reset_mid: tv=%b tb=%h dv=%b sb=%h busy=%b err=%h wait=%0d required all 0",
               tx_valid, tx_byte, spi_tx_dv, spi_tx_byte, busy, err_count, t);
    end
    m = mosi_q.size();
    r = resp_q.size();
    repeat (4) @(negedge clk40M);
    lat_q.delete();
    miso_q.delete();
    nRst = 1'b1;
    exp_err = 0;
    repeat (10) @(negedge clk40M);
    n_cmp++;
    if (mosi_q.size() != m || resp_q.size() != r) begin
      n_bad++;
      $display("FAIL reset_abandon: mosi %0d resp %0d required %0d and %0d",
               mosi_q.size(), resp_q.size(), m, r);
    end
    do_frame("wr_after_rst", 8'hA0, 32'h1234, 32'hABCD, 32'h0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_ping();
    test_errors();
    test_timeout();
    test_random();
    test_saturation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
